// File: rtl/vram_scroll_engine_if.sv
// Command and VRAM-port bundle for the scroll/clear engine.
// The engine takes the slave side; the register file plus the BRAM port form the master side.
interface vram_scroll_engine_if #(
    parameter int ADDR_W = 10
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [4:0]        cmd_rows;
    logic [31:0]       fill_word;
    logic              bram_en;
    logic [3:0]        bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_din;
    logic [31:0]       bram_dout;
    logic              busy;
    logic              done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rows, fill_word, bram_dout,
        output cmd_ready, bram_en, bram_we, bram_addr, bram_din, busy, done
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rows, fill_word, bram_dout,
        input  cmd_ready, bram_en, bram_we, bram_addr, bram_din, busy, done
    );
endinterface

// File: rtl/vram_scroll_engine.sv
// Screen-wide VRAM maintenance: clear (fill) and scroll-up by N text rows.
// Copies word-by-word in ascending order (read, then write), then fills the vacated tail.
module vram_scroll_engine #(
    parameter int WORDS_PER_ROW = 20,
    parameter int ROWS          = 30,
    parameter int ADDR_W        = 10
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    vram_scroll_engine_if.slave   bus
);
    localparam logic [ADDR_W-1:0] SCREEN_WORDS = ADDR_W'(ROWS * WORDS_PER_ROW);
    localparam logic [ADDR_W-1:0] LAST_WORD    = ADDR_W'(ROWS * WORDS_PER_ROW - 1);

    typedef enum logic [2:0] {IDLE, COPY_RD, COPY_WR, FILL, DONE} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] dst_reg, dst_next;
    logic [ADDR_W-1:0] copy_words_reg, copy_words_next;
    logic [ADDR_W-1:0] fill_words_reg, fill_words_next;
    logic [31:0]       fill_reg, fill_next;

    logic              degenerate;
    logic [ADDR_W-1:0] rows_eff;
    logic [ADDR_W-1:0] fill_words_calc;
    logic [ADDR_W-1:0] copy_words_calc;
    logic              accept;

    // Oversized scrolls collapse to a full clear; zero-row scrolls and no-ops do nothing.
    always_comb begin
        degenerate = 1'b1;
        rows_eff   = '0;
        case (bus.cmd_op)
            2'b01: begin
                degenerate = 1'b0;
                rows_eff   = ADDR_W'(ROWS);
            end
            2'b10: begin
                if (bus.cmd_rows != 5'd0) begin
                    degenerate = 1'b0;
                    rows_eff   = (int'(bus.cmd_rows) >= ROWS) ? ADDR_W'(ROWS)
                                                              : ADDR_W'(bus.cmd_rows);
                end
            end
            default: ;
        endcase
        fill_words_calc = rows_eff * ADDR_W'(WORDS_PER_ROW);
        copy_words_calc = SCREEN_WORDS - fill_words_calc;
    end

    assign bus.cmd_ready = (state_reg == IDLE) && axi_aresetn;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        state_next      = state_reg;
        dst_next        = dst_reg;
        copy_words_next = copy_words_reg;
        fill_words_next = fill_words_reg;
        fill_next       = fill_reg;
        bus.bram_en     = 1'b0;
        bus.bram_we     = 4'h0;
        bus.bram_addr   = '0;
        bus.bram_din    = 32'h0;
        bus.busy        = (state_reg != IDLE);
        bus.done        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    dst_next        = '0;
                    copy_words_next = copy_words_calc;
                    fill_words_next = fill_words_calc;
                    fill_next       = bus.fill_word;
                    if (degenerate)
                        state_next = DONE;
                    else if (copy_words_calc != '0)
                        state_next = COPY_RD;
                    else
                        state_next = FILL;
                end
            end
            COPY_RD: begin
                bus.bram_en   = 1'b1;
                bus.bram_addr = dst_reg + fill_words_reg;
                state_next    = COPY_WR;
            end
            COPY_WR: begin
                // Read data arrives one cycle after COPY_RD and goes straight back out.
                bus.bram_en   = 1'b1;
                bus.bram_we   = 4'hF;
                bus.bram_addr = dst_reg;
                bus.bram_din  = bus.bram_dout;
                dst_next      = dst_reg + 1'b1;
                state_next    = (dst_reg == copy_words_reg - 1'b1) ? FILL : COPY_RD;
            end
            FILL: begin
                bus.bram_en   = 1'b1;
                bus.bram_we   = 4'hF;
                bus.bram_addr = dst_reg;
                bus.bram_din  = fill_reg;
                if (dst_reg == LAST_WORD)
                    state_next = DONE;
                else
                    dst_next = dst_reg + 1'b1;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state_reg      <= IDLE;
            dst_reg        <= '0;
            copy_words_reg <= '0;
            fill_words_reg <= '0;
            fill_reg       <= 32'h0;
        end else begin
            state_reg      <= state_next;
            dst_reg        <= dst_next;
            copy_words_reg <= copy_words_next;
            fill_words_reg <= fill_words_next;
            fill_reg       <= fill_next;
        end
    end
endmodule

// File: doc/vram_scroll_engine.md
# vram_scroll_engine

Hardware command engine that performs screen-wide VRAM maintenance for the HDMI text controller: clear-screen (fill) and scroll-up by N text rows. It sits between the AXI register file, which issues commands, and one port of the VRAM block RAM, which it drives directly while busy. VRAM holds 80x30 characters, 4 glyph bytes per 32-bit word: 20 words per text row, 600 words total. The display fetch path is not coordinated with the engine; visible tearing during an operation is accepted.

## Interface
- WORDS_PER_ROW, 20, 32-bit VRAM words per text row.
- ROWS, 30, text rows on screen.
- ADDR_W, 10, VRAM word-address width.

- axi_aclk  in  1  sole clock.
- axi_aresetn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle; a command is accepted on an edge where cmd_valid && cmd_ready.
- cmd_op  in  2  01 = CLEAR, 10 = SCROLL, 00/11 = no-op.
- cmd_rows  in  5  rows to scroll (SCROLL only).
- fill_word  in  32  word written to cleared or vacated locations.
- bram_en  out  1  BRAM port enable.
- bram_we  out  4  byte write enables.
- bram_addr  out  ADDR_W  word address.
- bram_din  out  32  write data.
- bram_dout  in  32  read data; 1-cycle latency, no output register.
- busy  out  1  high from the cycle after accept through the DONE cycle.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, COPY_RD, COPY_WR, FILL, DONE.
- On accept, latch op, rows, and fill_word. Compute:
  - N = rows for SCROLL; N = ROWS for CLEAR.
  - C = (ROWS-N)*WORDS_PER_ROW words to copy.
  - F = N*WORDS_PER_ROW words to fill.
- Degenerate commands:
  - SCROLL with cmd_rows = 0 goes directly to DONE.
  - No-op goes directly to DONE.
  - SCROLL with cmd_rows >= ROWS is executed as CLEAR.
- IDLE -> COPY_RD if C > 0, else FILL; DONE for degenerate commands.
- Copy loop, for dst = 0 .. C-1, with src = dst + F:
  - COPY_RD: en=1, we=0, addr=src.
  - COPY_WR: en=1, we=4'hF, addr=dst, din=bram_dout (combinational pass-through).
  - COPY_WR -> COPY_RD while dst < C-1; otherwise -> FILL.
- FILL: for dst = C .. C+F-1, one word per cycle: en=1, we=4'hF, addr=dst, din = latched fill_word. After the last word -> DONE.
- DONE: done=1, en=0, we=0 -> IDLE.
- Ascending-address copy is correct because src > dst always.
- Address counters are ADDR_W bits wide and never exceed ROWS*WORDS_PER_ROW-1.
- BRAM control outputs (en, we, addr) are decoded from state and counter registers only; there is no combinational path from cmd_* to bram_*.

## Timing
- Reset (axi_aresetn low at an edge):
  - state = IDLE.
  - bram_en = 0, bram_we = 0, bram_addr = 0, bram_din = 0, busy = 0, done = 0.
  - cmd_ready = 0 while axi_aresetn is low; 1 in the first cycle after release.
- Accept at edge E0. Cycle k is the k-th cycle after E0:
  - Copy occupies cycles 1..2C.
  - Fill occupies cycles 2C+1 .. 2C+F.
  - done is high in cycle 2C+F+1.
  - cmd_ready returns high in cycle 2C+F+2.
- Worked totals:
  - CLEAR: done in cycle 601.
  - SCROLL 1: C=580, F=20, done in cycle 1181.
  - SCROLL 29: done in cycle 621.
  - Degenerate command: done in cycle 1.
- cmd_valid while busy is ignored; there is no queuing. The requester must hold cmd_valid until cmd_ready.
- Reset mid-operation aborts immediately. VRAM keeps whatever has already been written (no rollback), and no done pulse is issued.

## Test plan
- Reset values: hold reset 3 cycles -> all outputs 0 and cmd_ready 0; after release, cmd_ready = 1 and bram_en = 0.
- CLEAR: fill_word = 32'h20202020 -> 600 writes to addresses 0..599 in ascending order, no reads; done in cycle 601; the BRAM model reads all 0x20202020.
- SCROLL 1:
  - Setup: preload word[i] = i.
  - Required: word[i] = i+20 for i < 580, word[i] = fill for i >= 580.
  - Required: COPY_RD/COPY_WR strictly alternating; done in cycle 1181.
- SCROLL 29 and edge counts:
  - Required for SCROLL 29: word[0..19] = 580..599, remainder = fill, done in cycle 621.
  - Required for rows = 0: done in cycle 1, zero writes.
  - Required for rows = 30 or 31: identical to CLEAR.
- Busy rule: second cmd_valid pulses during a scroll -> ignored, exactly one done. The new command is accepted in the cycle after done.
- Abort: assert reset at cycle 300 of SCROLL 1 -> outputs zero next edge, no done pulse. A following CLEAR completes normally.
